mem_port_arbiter: RTL and testbench

- Sits between the pipelined core and the single-ported, big-endian unified memory (1024-byte address space, four byte banks, combinational read, write at posedge).
- Arbitrates each cycle between the IF-stage instruction fetch and the MEM-stage data access.
- Drives the memory port and registers the memory read data into one-cycle-later responses.
- Raises per-stage stalls, and blocks illegal or out-of-range accesses before they reach memory.

---
 rtl/mem_pkg.sv | 18 +
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_access_check.sv | 21 ++
 rtl/mem_port_arbiter.sv | 79 +++++++
 tb/tb_mem_port_arbiter.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared memory access types, widths and size decode
package mem_pkg;

    localparam int MEM_ADDR_W = 10;

    localparam logic [1:0] MEMTYPE_W   = 2'b00;
    localparam logic [1:0] MEMTYPE_H   = 2'b01;
    localparam logic [1:0] MEMTYPE_B   = 2'b10;
    localparam logic [1:0] MEMTYPE_ILL = 2'b11;

    typedef logic [MEM_ADDR_W-1:0] mem_addr_t;

    // Illegal type reports one byte so range arithmetic never underflows.
    function automatic logic [2:0] size_of(input logic [1:0] t);
        return t == MEMTYPE_W ? 3'd4 : t == MEMTYPE_H ? 3'd2 : 3'd1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: core-side requests, memory port and responses of the arbiter
interface mem_port_arbiter_if;
    import mem_pkg::*;

    logic            if_req;
    mem_addr_t       if_addr;
    logic            dm_req;
    logic            dm_we;
    mem_addr_t       dm_addr;
    logic [31:0]     dm_wdata;
    logic            dm_u;
    logic [1:0]      dm_type;
    logic            mem_we;
    mem_addr_t       mem_addr;
    logic [31:0]     mem_data_in;
    logic            mem_u;
    logic [1:0]      mem_type;
    logic [31:0]     mem_data_out;
    logic            stall_if;
    logic            stall_dm;
    logic            if_rvalid;
    logic [31:0]     if_rdata;
    logic            dm_rvalid;
    logic [31:0]     dm_rdata;
    logic            dm_err;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_u, dm_type, mem_data_out,
        output mem_we, mem_addr, mem_data_in, mem_u, mem_type,
        output stall_if, stall_dm, if_rvalid, if_rdata, dm_rvalid, dm_rdata, dm_err
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_u, dm_type, mem_data_out,
        input  mem_we, mem_addr, mem_data_in, mem_u, mem_type,
        input  stall_if, stall_dm, if_rvalid, if_rdata, dm_rvalid, dm_rdata, dm_err
    );

endinterface

// File: rtl/mem_access_check.sv
// mem_access_check: flags illegal-type or out-of-range accesses from address and type
module mem_access_check
    import mem_pkg::*;
#(
    parameter int MEM_BYTES = 256
) (
    input  mem_addr_t   addr,
    input  logic [1:0]  mtype,
    output logic        bad
);

    localparam int LW = MEM_ADDR_W + 1;

    logic [LW-1:0] last;

    always_comb begin
        last = {1'b0, addr} + LW'(size_of(mtype)) - LW'(1);
        bad = (mtype == MEMTYPE_ILL) || (last > LW'(MEM_BYTES - 1));
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data access with a bounded data streak
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int MEM_BYTES     = 256,
    parameter int MAX_DM_STREAK = 4
) (
    input  logic clk,
    input  logic rst,
    mem_port_arbiter_if.slave bus
);

    localparam int SW = $clog2(MAX_DM_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

    logic [SW-1:0] streak_q, streak_d;
    logic          if_rvalid_q, if_rvalid_d;
    logic          dm_rvalid_q, dm_rvalid_d;
    logic          dm_err_q, dm_err_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [31:0]   dm_rdata_q, dm_rdata_d;
    logic          grant_if, grant_dm, if_bad, dm_bad;

    mem_access_check #(.MEM_BYTES(MEM_BYTES)) u_if_chk (
        .addr  (bus.if_addr),
        .mtype (MEMTYPE_W),
        .bad   (if_bad)
    );

    mem_access_check #(.MEM_BYTES(MEM_BYTES)) u_dm_chk (
        .addr  (bus.dm_addr),
        .mtype (bus.dm_type),
        .bad   (dm_bad)
    );

    always_comb begin
        grant_dm = bus.dm_req & (~bus.if_req | (streak_q < STREAK_MAX));
        grant_if = bus.if_req & ~grant_dm;
        streak_d = (bus.if_req & grant_dm) ? ((streak_q == STREAK_MAX) ? streak_q : streak_q + SW'(1)) : '0;
        bus.stall_if = bus.if_req & ~grant_if;
        bus.stall_dm = bus.dm_req & ~grant_dm;
        bus.mem_addr = grant_dm ? bus.dm_addr : grant_if ? bus.if_addr : '0;
        bus.mem_type = grant_dm ? bus.dm_type : MEMTYPE_W;
        bus.mem_u = grant_dm & bus.dm_u;
        bus.mem_data_in = grant_dm ? bus.dm_wdata : '0;
        // Reset gates the write strobe directly so no store can land while rst is high.
        bus.mem_we = ~rst & grant_dm & bus.dm_we & ~dm_bad;
        if_rvalid_d = grant_if;
        if_rdata_d = grant_if ? (if_bad ? '0 : bus.mem_data_out) : if_rdata_q;
        dm_rvalid_d = grant_dm;
        dm_rdata_d = grant_dm ? ((bus.dm_we | dm_bad) ? '0 : bus.mem_data_out) : dm_rdata_q;
        dm_err_d = grant_dm & dm_bad;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_q    <= '0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            dm_err_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            streak_q    <= streak_d;
            if_rvalid_q <= if_rvalid_d;
            dm_rvalid_q <= dm_rvalid_d;
            dm_err_q    <= dm_err_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rvalid = dm_rvalid_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.dm_err    = dm_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random checks of mem_port_arbiter against a byte-array reference model
module tb_mem_port_arbiter;

    localparam int MAX_RUN = 4;
    localparam int NBYTES  = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.MEM_BYTES(NBYTES), .MAX_DM_STREAK(MAX_RUN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0]  env_mem [NBYTES] = '{default: 8'h00};
    logic [7:0]  ref_mem [NBYTES] = '{default: 8'h00};
    logic [31:0] env_raw;

    int errors = 0;
    int checks = 0;
    int dm_run = 0;
    logic [31:0] last_dr = '0;
    logic [31:0] last_ir = '0;
    logic g_if = 1'b0;
    logic g_dm = 1'b0;
    logic seen_sif;

    function automatic int tsize(input logic [1:0] t);
        return t == 2'b00 ? 4 : t == 2'b01 ? 2 : 1;
    endfunction

    function automatic logic [31:0] ext(input logic [31:0] raw, input logic [1:0] t, input logic u);
        if (t == 2'b00) return raw;
        if (t == 2'b01) return u ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
        return u ? {24'h0, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
    endfunction

    // Big-endian memory seen by the DUT: combinational read, write at posedge.
    always_comb begin
        env_raw = '0;
        for (int i = 0; i < 4; i++)
            if (i < tsize(bus.mem_type))
                env_raw = {env_raw[23:0], (int'(bus.mem_addr) + i < NBYTES) ? env_mem[8'(int'(bus.mem_addr) + i)] : 8'h00};
        bus.mem_data_out = ext(env_raw, bus.mem_type, bus.mem_u);
    end

    always @(posedge clk)
        if (bus.mem_we)
            for (int i = 0; i < tsize(bus.mem_type); i++)
                if (int'(bus.mem_addr) + i < NBYTES)
                    env_mem[8'(int'(bus.mem_addr) + i)] <= bus.mem_data_in[8*(tsize(bus.mem_type)-1-i) +: 8];

    function automatic logic rbad(input logic [9:0] a, input logic [1:0] t);
        return t == 2'b11 || int'(a) + tsize(t) > NBYTES;
    endfunction

    function automatic logic [31:0] rload(input logic [9:0] a, input logic [1:0] t, input logic u);
        logic [31:0] raw = '0;
        for (int i = 0; i < tsize(t); i++) raw = {raw[23:0], ref_mem[8'(int'(a) + i)]};
        return ext(raw, t, u);
    endfunction

    function automatic logic [31:0] rfetch(input logic [9:0] a);
        return int'(a) + 4 > NBYTES ? 32'h0 : rload(a, 2'b00, 1'b0);
    endfunction

    task automatic rstore(input logic [9:0] a, input logic [1:0] t, input logic [31:0] d);
        for (int i = 0; i < tsize(t); i++) ref_mem[8'(int'(a) + i)] = d[8*(tsize(t)-1-i) +: 8];
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.if_req = 0; bus.if_addr = '0;
        bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = '0; bus.dm_wdata = '0; bus.dm_u = 0; bus.dm_type = 2'b00;
    endtask

    task automatic dm(input logic we, input logic [9:0] a, input logic [1:0] t, input logic [31:0] d, input logic u);
        bus.dm_req = 1; bus.dm_we = we; bus.dm_addr = a; bus.dm_type = t; bus.dm_wdata = d; bus.dm_u = u;
    endtask

    function automatic logic [9:0] raddr();
        return ($urandom % 8 == 0) ? 10'($urandom_range(240, 1023)) : 10'($urandom_range(0, NBYTES - 1));
    endfunction

    // One clock of traffic: expectations come from the model before the edge, outputs checked after it.
    task automatic cyc(input string tag);
        logic e_dm, e_if, bad;
        logic [31:0] e_dr, e_ir;
        e_dm = bus.dm_req && (!bus.if_req || dm_run < MAX_RUN);
        e_if = bus.if_req && !e_dm;
        bad = rbad(bus.dm_addr, bus.dm_type);
        e_dr = !e_dm ? last_dr : (bus.dm_we || bad) ? 32'h0 : rload(bus.dm_addr, bus.dm_type, bus.dm_u);
        e_ir = e_if ? rfetch(bus.if_addr) : last_ir;
        @(negedge clk);
        seen_sif = bus.stall_if;
        chk({tag, ":stall_if"}, 32'(bus.stall_if), 32'(bus.if_req && !e_if));
        chk({tag, ":stall_dm"}, 32'(bus.stall_dm), 32'(bus.dm_req && !e_dm));
        chk({tag, ":mem_we"}, 32'(bus.mem_we), 32'(e_dm && bus.dm_we && !bad));
        @(posedge clk);
        #1;
        if (e_dm && bus.dm_we && !bad) rstore(bus.dm_addr, bus.dm_type, bus.dm_wdata);
        dm_run = (bus.if_req && e_dm) ? dm_run + 1 : 0;
        chk({tag, ":if_rvalid"}, 32'(bus.if_rvalid), 32'(e_if));
        chk({tag, ":dm_rvalid"}, 32'(bus.dm_rvalid), 32'(e_dm));
        chk({tag, ":dm_err"}, 32'(bus.dm_err), 32'(e_dm && bad));
        chk({tag, ":if_rdata"}, bus.if_rdata, e_ir);
        chk({tag, ":dm_rdata"}, bus.dm_rdata, e_dr);
        last_dr = e_dr;
        last_ir = e_ir;
        g_if = e_if;
        g_dm = e_dm;
    endtask

    initial begin
        logic exp_sif [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst:if_rvalid", 32'(bus.if_rvalid), 32'h0);
        chk("rst:dm_rvalid", 32'(bus.dm_rvalid), 32'h0);
        chk("rst:dm_err", 32'(bus.dm_err), 32'h0);
        chk("rst:if_rdata", bus.if_rdata, 32'h0);
        chk("rst:dm_rdata", bus.dm_rdata, 32'h0);
        chk("rst:mem_we", 32'(bus.mem_we), 32'h0);
        rst = 0;
        @(posedge clk);
        #1;

        dm(1, 10'h040, 2'b00, 32'hCAFEF00D, 0); cyc("st40");
        dm(1, 10'h000, 2'b00, 32'h00000013, 0); cyc("st00");

        bus.if_req = 1; bus.if_addr = 10'h000;
        dm(0, 10'h040, 2'b00, 32'h0, 0);
        cyc("pre_rst0"); cyc("pre_rst1");

        dm(1, 10'h040, 2'b00, 32'h11111111, 0);
        @(negedge clk);
        rst = 1;
        #1;
        chk("rst_mid:mem_we", 32'(bus.mem_we), 32'h0);
        @(posedge clk);
        #1;
        chk("rst_mid:dm_rvalid", 32'(bus.dm_rvalid), 32'h0);
        chk("rst_mid:if_rvalid", 32'(bus.if_rvalid), 32'h0);
        @(negedge clk);
        rst = 0;
        idle();
        dm_run = 0; last_dr = '0; last_ir = '0;
        cyc("post_rst");
        for (int i = 0; i < 4; i++) chk("rst_mid:mem", 32'(env_mem[8'h40 + 8'(i)]), 32'(ref_mem[8'h40 + 8'(i)]));

        bus.if_req = 1; bus.if_addr = 10'h000;
        dm(0, 10'h040, 2'b00, 32'h0, 0);
        for (int c = 0; c < 6; c++) begin
            cyc("contend");
            chk("contend:pattern", 32'(seen_sif), 32'(exp_sif[c]));
        end
        idle();

        bus.if_req = 1; bus.if_addr = 10'h000; cyc("fetch");
        chk("fetch:word", bus.if_rdata, 32'h00000013);
        idle(); cyc("fetch_idle");

        dm(1, 10'h010, 2'b00, 32'hDEADBEEF, 0); cyc("st10");
        dm(0, 10'h010, 2'b10, 32'h0, 1); cyc("lbu10");
        chk("lbu10:val", bus.dm_rdata, 32'h000000DE);
        dm(0, 10'h011, 2'b10, 32'h0, 0); cyc("lb11");
        chk("lb11:val", bus.dm_rdata, 32'hFFFFFFAD);
        idle(); cyc("ld_idle");

        dm(1, 10'h013, 2'b01, 32'h0000BEEF, 0); cyc("sh13");
        dm(0, 10'h013, 2'b01, 32'h0, 0); cyc("lh13");
        chk("lh13:val", bus.dm_rdata, 32'hFFFFBEEF);
        chk("sh13:b13", 32'(env_mem[8'h13]), 32'h000000BE);
        chk("sh13:b14", 32'(env_mem[8'h14]), 32'h000000EF);

        dm(1, 10'h0FE, 2'b00, 32'h12345678, 0); cyc("st_oob");
        chk("st_oob:err", 32'(bus.dm_err), 32'h1);
        chk("st_oob:rdata", bus.dm_rdata, 32'h0);
        dm(1, 10'h020, 2'b11, 32'hA5A5A5A5, 0); cyc("st_ill");
        chk("st_ill:err", 32'(bus.dm_err), 32'h1);
        for (int i = 0; i < 4; i++) chk("st_ill:mem", 32'(env_mem[8'h20 + 8'(i)]), 32'h0);
        idle();
        bus.if_req = 1; bus.if_addr = 10'h0FE; cyc("fetch_oob");
        idle(); cyc("idle");

        for (int k = 0; k < 300; k++) begin
            if (!bus.if_req || g_if) begin
                bus.if_req = ($urandom % 4) != 0;
                bus.if_addr = raddr();
            end
            if (!bus.dm_req || g_dm) begin
                dm(1'($urandom), raddr(), 2'($urandom), $urandom, 1'($urandom));
                bus.dm_req = ($urandom % 4) != 0;
            end
            cyc("rnd");
        end
        idle(); cyc("final");
        for (int i = 0; i < NBYTES; i++) chk("final:mem", 32'(env_mem[i]), 32'(ref_mem[i]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
